// File: rtl/gameconsole_pkg.sv
// gameconsole_pkg: shared VRAM geometry constants and background fetcher types.
package gameconsole_pkg;
  localparam int MAP_ADDR_W  = 12;
  localparam int TILE_IDX_W  = 10;
  localparam int MAP_DATA_W  = TILE_IDX_W + 4;
  localparam int TILE_ADDR_W = TILE_IDX_W + 3;
  localparam int TILE_DATA_W = 32;
  localparam int PAL_ADDR_W  = 8;
  localparam int PAL_DATA_W  = 16;
  typedef struct packed {
    logic [3:0]            pal_row;
    logic [TILE_IDX_W-1:0] tile_idx;
  } bg_map_entry_t;
  typedef enum logic [2:0] {IDLE, MAP, TILE, PIX, DRAIN} bg_fetch_state_e;
endpackage

// File: rtl/bg_pix_pipe.sv
// bg_pix_pipe: one-stage register carrying a palette read issue to its line buffer write.
module bg_pix_pipe #(
  parameter int PIX_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue,
  input  logic                  skip,
  input  logic [PIX_ADDR_W-1:0] x,
  output logic                  we,
  output logic [PIX_ADDR_W-1:0] addr
);
  logic valid, hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      hold  <= 1'b0;
      addr  <= '0;
    end else begin
      valid <= issue;
      hold  <= skip;
      if (issue) addr <= x;
    end
  assign we = valid & ~hold;
endmodule

// File: rtl/bg_line_fetcher.sv
// bg_line_fetcher: fetches one background scanline (map -> tile -> palette) into the line buffer.
// Optional BG_TRANSPARENT_EN: colour index 0 issues no palette read and no write.
module bg_line_fetcher
  import gameconsole_pkg::*;
#(
  parameter int SCREEN_W   = 256,
  parameter int MAP_W_LOG2 = 6,
  parameter int TILE_IDX_W = 10,
  parameter int PIX_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8:0]             line_y,
  input  logic [15:0]            scroll_x,
  input  logic [15:0]            scroll_y,
  output logic                   busy,
  output logic                   done,
  output logic                   map_ram_enb,
  output logic [MAP_ADDR_W-1:0]  map_ram_addrb,
  input  logic [MAP_DATA_W-1:0]  map_ram_doutb,
  output logic                   tile_ram_enb,
  output logic [TILE_ADDR_W-1:0] tile_ram_addrb,
  input  logic [TILE_DATA_W-1:0] tile_ram_doutb,
  output logic                   pal_ram_enb,
  output logic [PAL_ADDR_W-1:0]  pal_ram_addrb,
  input  logic [PAL_DATA_W-1:0]  pal_ram_doutb,
  output logic                   pix_we,
  output logic [PIX_ADDR_W-1:0]  pix_addr,
  output logic [PAL_DATA_W-1:0]  pix_data
);
  bg_fetch_state_e        state;
  logic [15:0]            wy, wx0, wx;
  logic [PIX_ADDR_W:0]    x;
  logic [3:0]             pal_row, pixel;
  logic [TILE_DATA_W-1:0] tile_word, row;
  logic                   fresh, pix_st, skip;
  bg_map_entry_t          me;
  assign me     = bg_map_entry_t'(map_ram_doutb);
  assign wx     = wx0 + 16'(x);
  assign pix_st = state == PIX;
  // the first PIX cycle of a tile reads the tile row straight off the RAM bus
  assign row    = fresh ? tile_ram_doutb : tile_word;
  assign pixel  = 4'(row >> {wx[2:0], 2'b00});
`ifdef BG_TRANSPARENT_EN
  assign skip = pixel == 4'd0;
`else
  assign skip = 1'b0;
`endif
  assign busy           = state != IDLE;
  assign done           = state == DRAIN;
  assign map_ram_enb    = state == MAP;
  assign map_ram_addrb  = map_ram_enb ? MAP_ADDR_W'({MAP_W_LOG2'(wy >> 3), MAP_W_LOG2'(wx >> 3)}) : '0;
  assign tile_ram_enb   = state == TILE;
  assign tile_ram_addrb = tile_ram_enb ? TILE_ADDR_W'({TILE_IDX_W'(me.tile_idx), wy[2:0]}) : '0;
  assign pal_ram_enb    = pix_st & ~skip;
  assign pal_ram_addrb  = pal_ram_enb ? PAL_ADDR_W'({pal_row, pixel}) : '0;
  assign pix_data       = pix_we ? pal_ram_doutb : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      wy        <= '0;
      wx0       <= '0;
      x         <= '0;
      pal_row   <= '0;
      tile_word <= '0;
      fresh     <= 1'b0;
    end else begin
      fresh <= state == TILE;
      case (state)
        IDLE:
          if (start) begin
            wy    <= 16'(line_y) + scroll_y;
            wx0   <= scroll_x;
            x     <= '0;
            state <= MAP;
          end
        MAP:   state <= TILE;
        TILE: begin
          pal_row <= me.pal_row;
          state   <= PIX;
        end
        PIX: begin
          if (fresh) tile_word <= tile_ram_doutb;
          x     <= x + 1'b1;
          state <= (x == (PIX_ADDR_W+1)'(SCREEN_W - 1)) ? DRAIN : (wx[2:0] == 3'd7) ? MAP : PIX;
        end
        default: state <= IDLE;
      endcase
    end
  bg_pix_pipe #(.PIX_ADDR_W(PIX_ADDR_W)) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .issue (pix_st),
    .skip  (skip),
    .x     (x[PIX_ADDR_W-1:0]),
    .we    (pix_we),
    .addr  (pix_addr)
  );
endmodule

// File: doc/bg_line_fetcher.md
Name: bg_line_fetcher

Overview:
- Reads one background scanline from VRAM through the VPU-side read ports (map, tile, palette), one scanline per start pulse.
- Drives map_ram_enb/addrb, tile_ram_enb/addrb and pal_ram_enb/addrb, and consumes the matching doutb buses, which have 1-cycle registered read latency.
- Writes resolved RGB pixels into a line buffer write port.
- Sits in the VPU between the VRAM block and the line-buffer/compositor.

Parameters:
- SCREEN_W, 256: pixels per scanline; must be a multiple of 8.
- MAP_W_LOG2, 6: log2 of map width/height in tiles (64x64 map).
- TILE_IDX_W, 10: tile-index field width in a map entry.
- PIX_ADDR_W, 8: line buffer address width (clog2 SCREEN_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a line fetch; ignored while busy.
- line_y  in  9  screen line number.
- scroll_x  in  16  BG scroll X in pixels.
- scroll_y  in  16  BG scroll Y in pixels.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel write.
- map_ram_enb  out  1  map read enable.
- map_ram_addrb  out  MAP_ADDR_W  map read address.
- map_ram_doutb  in  MAP_DATA_W  map read data, valid 1 cycle after enb.
- tile_ram_enb  out  1  tile read enable.
- tile_ram_addrb  out  TILE_ADDR_W  tile read address.
- tile_ram_doutb  in  TILE_DATA_W  tile row (8 px x 4 bpp), 1-cycle latency.
- pal_ram_enb  out  1  palette read enable.
- pal_ram_addrb  out  PAL_ADDR_W  palette read address.
- pal_ram_doutb  in  PAL_DATA_W  RGB colour, 1-cycle latency.
- pix_we  out  1  line buffer write strobe.
- pix_addr  out  PIX_ADDR_W  screen X of the pixel.
- pix_data  out  PAL_DATA_W  RGB colour.

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE.
- Reset mid-line: abort immediately; no done pulse; the partial line is left in the buffer.
- On an accepted start, latch wy = line_y + scroll_y and wx0 = scroll_x (both mod 2^16). Set x = 0.
- World X per pixel is wx = wx0 + x.
- Map address = {wy[MAP_W_LOG2+2:3], wx[MAP_W_LOG2+2:3]}, zero-extended to MAP_ADDR_W. The map wraps naturally by truncation.
- Map entry fields:
  - [TILE_IDX_W-1:0] = tile index.
  - [TILE_IDX_W+3:TILE_IDX_W] = palette row.
- Tile address = {tile_idx, wy[2:0]}.
- Pixel k = tile_word[4k+3:4k], where k = wx[2:0]; k = 0 is the leftmost pixel.
- Palette address = {pal_row, pixel}.
- FSM states:
  - IDLE: wait for start, then go to MAP.
  - MAP: pulse map_ram_enb; next state TILE.
  - TILE: latch map_ram_doutb fields; pulse tile_ram_enb; next state PIX.
  - PIX: on entry from TILE, latch tile_ram_doutb. Every PIX cycle pulse pal_ram_enb for the current x, then x++.
  - Leaving PIX:
    - If x == SCREEN_W after the increment, go to DRAIN.
    - Else if the new wx[2:0] == 0, go to MAP.
    - Else stay in PIX.
  - DRAIN: performs the last pixel write; next state IDLE, with done pulsed in the same cycle as that last write.
- Write pipeline: the pal read issued in cycle t produces pix_we = 1 in cycle t+1, with pix_addr = that x and pix_data = pal_ram_doutb. Writes overlap the following MAP/TILE cycles.
- Exactly one pal read and one write per pixel. pix_addr increases strictly monotonically from 0 to SCREEN_W-1.
- Line time = SCREEN_W + 2·ntiles + 1 cycles from the start cycle to done, where ntiles = SCREEN_W/8 + (scroll_x[2:0] != 0).
  - SCREEN_W = 256, fine X = 0: 321 cycles.
  - Fine X = 3: 323 cycles.
- Never assert more than one enb of the same RAM per cycle. The write ports (web/dinb) are not driven by this block.
- start in the same cycle as done: ignored, because busy is still high.

Optional Feature:
- Macro: BG_TRANSPARENT_EN.
- Defined: pixels with 4-bit value 0 issue no pal read and no pix_we. Timing is unchanged; the slot is idle.
- Undefined: value 0 is treated like any other colour index.

Decomposition:
- gameconsole_pkg gains:
  - a bg_map_entry_t packed struct (tile_idx, pal_row);
  - TILE_IDX_W;
  - a bg_fetch_state_e enum (IDLE, MAP, TILE, PIX, DRAIN).
- Existing MAP/TILE/PAL _ADDR_W/_DATA_W constants are reused.
- Sub-module bg_pix_pipe: the one-stage pal-read-to-write register (valid, x, transparent flag).

Test Plan:
- scroll 0/0, line_y 0, map[0] = tile 1 pal 2, tile row 0x76543210 -> pix_addr 0..7 get pal[0x20..0x27]; done at cycle 321; busy falls with done.
- scroll_x = 3 -> first write pix_addr 0 uses tile pixel 3; 33 map reads; done at 323.
- scroll_x = 0xFFF8, scroll_y = 0x01F8 -> map address wraps to column 63 then column 0, row 63; no out-of-range address.
- start pulsed at cycle 5 during busy -> ignored; exactly 256 writes.
- rst_n low at pixel 100 -> all outputs 0 next cycle; no done; a fresh start then completes normally.
- BG_TRANSPARENT_EN, tile row 0x00000001 -> only pixel 0 written per tile; cycle count unchanged.
